// File: rtl/int_divide_unit.sv
`default_nettype none
// ============================================================================
// Module     : int_divide_unit
// Description: Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//              Produces one quotient bit per cycle. Accepts one op through a
//              valid/ready handshake and returns one tagged result as a
//              single-cycle pulse. The output has no backpressure.
//
//              Optional build macro:
//                DIV_EARLY_OUT_EN - special cases (b==0, signed overflow) and
//                divisor-magnitude > dividend-magnitude skip the iteration
//                loop and go straight to FINISH.
//
// Ports      : clk          clock, rising edge
//              rst_n        asynchronous active-low reset
//              flush        synchronous kill of the in-flight op
//              issue_valid  op presented
//              issue_ready  unit idle, can accept
//              issue_op     00 DIV, 01 DIVU, 10 REM, 11 REMU
//              issue_a      dividend (rs1)
//              issue_b      divisor  (rs2)
//              issue_tag    ROB tag
//              res_valid    one-cycle result pulse
//              res_value    quotient or remainder
//              res_tag      tag of the completing op
//              busy         op in flight
// Revision   : 1.0 - initial release
// ============================================================================
module int_divide_unit #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [1:0]       issue_op,
   input  logic [XLEN-1:0]  issue_a,
   input  logic [XLEN-1:0]  issue_b,
   input  logic [TAG_W-1:0] issue_tag,
   output logic             res_valid,
   output logic [XLEN-1:0]  res_value,
   output logic [TAG_W-1:0] res_tag,
   output logic             busy
);

   localparam int                 c_cnt_w     = $clog2(XLEN);
   localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(XLEN - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
   localparam logic [XLEN-1:0]    c_min_int   = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0]    c_all_ones  = {XLEN{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BUSY   = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [c_cnt_w-1:0] r_cnt;
   logic [XLEN-1:0]    r_q;
   logic [XLEN-1:0]    r_rem;
   logic [XLEN-1:0]    r_div;
   logic               r_neg_q;
   logic               r_neg_r;
   logic               r_op_rem;
   logic               r_special;
   logic [XLEN-1:0]    r_spec_val;
   logic [TAG_W-1:0]   r_tag;
   logic               r_res_valid;
   logic [XLEN-1:0]    r_res_value;
   logic [TAG_W-1:0]   r_res_tag;

   // ------------------------------------------------------------------------
   // Accept-side decode
   // ------------------------------------------------------------------------
   logic            w_accept;
   logic            w_signed;
   logic            w_sa;
   logic            w_sb;
   logic [XLEN-1:0] w_a_mag;
   logic [XLEN-1:0] w_b_mag;
   logic            w_b_zero;
   logic            w_ovf;
   logic            w_special;
   logic [XLEN-1:0] w_spec_val;
   logic            w_early;

   assign issue_ready = (r_state == S_IDLE);
   assign busy        = (r_state != S_IDLE);
   assign w_accept    = issue_valid & issue_ready & ~flush;

   // DIV and REM (op[0]==0) are the signed flavours
   assign w_signed  = ~issue_op[0];
   assign w_sa      = w_signed & issue_a[XLEN-1];
   assign w_sb      = w_signed & issue_b[XLEN-1];
   // Negating the most negative value wraps back to itself, which is still
   // the correct unsigned magnitude.
   assign w_a_mag   = w_sa ? -issue_a : issue_a;
   assign w_b_mag   = w_sb ? -issue_b : issue_b;
   assign w_b_zero  = (issue_b == '0);
   assign w_ovf     = w_signed & (issue_a == c_min_int) & (issue_b == c_all_ones);
   assign w_special = w_b_zero | w_ovf;

   always_comb begin
      w_spec_val = '0;
      if (w_b_zero) begin
         w_spec_val = issue_op[1] ? issue_a : c_all_ones;
      end else begin
         w_spec_val = issue_op[1] ? '0 : c_min_int;
      end
   end

`ifdef DIV_EARLY_OUT_EN
   assign w_early = w_special | (w_b_mag > w_a_mag);
`else
   assign w_early = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Restoring step. The shifted partial remainder needs XLEN+1 bits; the
   // stored remainder is always below the divisor so XLEN bits suffice, and
   // the difference (taken only when it is non-negative) also fits in XLEN.
   // ------------------------------------------------------------------------
   logic [XLEN:0]   w_rem_sh;
   logic            w_ge;
   logic [XLEN-1:0] w_rem_sub;

   assign w_rem_sh  = {r_rem, r_q[XLEN-1]};
   assign w_ge      = (w_rem_sh >= {1'b0, r_div});
   assign w_rem_sub = w_rem_sh[XLEN-1:0] - r_div;

   // ------------------------------------------------------------------------
   // Sign fix and special-case override
   // ------------------------------------------------------------------------
   logic [XLEN-1:0] w_quot;
   logic [XLEN-1:0] w_remv;
   logic [XLEN-1:0] w_result;

   assign w_quot   = r_neg_q ? -r_q : r_q;
   assign w_remv   = r_neg_r ? -r_rem : r_rem;
   assign w_result = r_special ? r_spec_val : (r_op_rem ? w_remv : w_quot);

   // ------------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  w_state_nxt = w_early ? S_FINISH : S_BUSY;
               end
            end
            S_BUSY: begin
               if (r_cnt == c_last_iter) begin
                  w_state_nxt = S_FINISH;
               end
            end
            S_FINISH: begin
               w_state_nxt = S_IDLE;
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Datapath and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_q         <= '0;
         r_rem       <= '0;
         r_div       <= '0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_op_rem    <= 1'b0;
         r_special   <= 1'b0;
         r_spec_val  <= '0;
         r_tag       <= '0;
         r_res_valid <= 1'b0;
         r_res_value <= '0;
         r_res_tag   <= '0;
      end else begin
         // A flush landing in FINISH discards the pending result
         r_res_valid <= (r_state == S_FINISH) & ~flush;
         if ((r_state == S_FINISH) && !flush) begin
            r_res_value <= w_result;
            r_res_tag   <= r_tag;
         end

         if (flush) begin
            r_cnt <= '0;
         end else if (w_accept) begin
            r_cnt      <= '0;
            r_div      <= w_b_mag;
            r_neg_q    <= w_sa ^ w_sb;
            r_neg_r    <= w_sa;
            r_op_rem   <= issue_op[1];
            r_special  <= w_special;
            r_spec_val <= w_spec_val;
            r_tag      <= issue_tag;
            // Early-out preloads the final answer: q=0, rem=|a|
            r_q        <= w_early ? '0 : w_a_mag;
            r_rem      <= w_early ? w_a_mag : '0;
         end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt + c_cnt_one;
            r_q   <= {r_q[XLEN-2:0], w_ge};
            r_rem <= w_ge ? w_rem_sub : w_rem_sh[XLEN-1:0];
         end
      end
   end

   assign res_valid = r_res_valid;
   assign res_value = r_res_value;
   assign res_tag   = r_res_tag;

endmodule
`default_nettype wire

// File: tb/tb_int_divide_unit.sv
`default_nettype none
// ============================================================================
// Module     : tb_int_divide_unit
// Description: Self-checking bench for int_divide_unit. Directed cases plus
//              randomized ops compared against an arithmetic reference model.
//              Honours DIV_EARLY_OUT_EN for expected latency.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_int_divide_unit;

   localparam int XLEN  = 32;
   localparam int TAG_W = 6;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             flush;
   logic             issue_valid;
   logic             issue_ready;
   logic [1:0]       issue_op;
   logic [XLEN-1:0]  issue_a;
   logic [XLEN-1:0]  issue_b;
   logic [TAG_W-1:0] issue_tag;
   logic             res_valid;
   logic [XLEN-1:0]  res_value;
   logic [TAG_W-1:0] res_tag;
   logic             busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   int_divide_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue_op    (issue_op),
      .issue_a     (issue_a),
      .issue_b     (issue_b),
      .issue_tag   (issue_tag),
      .res_valid   (res_valid),
      .res_value   (res_value),
      .res_tag     (res_tag),
      .busy        (busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // RISC-V M-extension semantics expressed with plain arithmetic
   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      logic sgn;
      logic is_rem;
      sgn    = (op[0] == 1'b0);
      is_rem = op[1];
      if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return is_rem ? 32'd0 : 32'h8000_0000;
      if (sgn) return is_rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
      return is_rem ? a % b : a / b;
   endfunction

   function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
      logic        sgn;
      logic [31:0] ma;
      logic [31:0] mb;
      sgn = (op[0] == 1'b0);
      ma  = (sgn && a[31]) ? 32'(-a) : a;
      mb  = (sgn && b[31]) ? 32'(-b) : b;
      if (b == 32'd0) return 2;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      if (mb > ma) return 2;
`endif
      return 34;
   endfunction

   // Called just after a negedge with the unit idle; returns after a negedge
   task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] tag);
      int lat;
      check({name, "/ready"}, 64'(issue_ready), 64'd1);
      issue_valid = 1'b1;
      issue_op    = op;
      issue_a     = a;
      issue_b     = b;
      issue_tag   = tag;
      @(negedge clk);
      issue_valid = 1'b0;
      issue_op    = 2'($urandom);
      issue_a     = $urandom;
      issue_b     = $urandom;
      issue_tag   = 6'($urandom);
      check({name, "/busy"}, 64'(busy), 64'd1);
      lat = 1;
      while (!res_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check({name, "/latency"}, 64'(lat), 64'(ref_latency(op, a, b)));
      check({name, "/value"}, 64'(res_value), 64'(ref_result(op, a, b)));
      check({name, "/tag"}, 64'(res_tag), 64'(tag));
      @(negedge clk);
      check({name, "/pulse"}, 64'(res_valid), 64'd0);
   endtask

   task automatic count_pulses(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (res_valid) n++;
      end
   endtask

   initial begin
      int n;
      int lat;
      logic [1:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;

      rst_n       = 1'b0;
      flush       = 1'b0;
      issue_valid = 1'b0;
      issue_op    = 2'd0;
      issue_a     = '0;
      issue_b     = '0;
      issue_tag   = '0;
      repeat (3) @(negedge clk);
      check("rst/res_valid", 64'(res_valid), 64'd0);
      check("rst/res_value", 64'(res_value), 64'd0);
      check("rst/res_tag", 64'(res_tag), 64'd0);
      check("rst/busy", 64'(busy), 64'd0);
      check("rst/ready", 64'(issue_ready), 64'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases
      run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 6'd5);
      check("divu_100_7/const", 64'(ref_result(2'b01, 32'd100, 32'd7)), 64'd14);
      run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 6'd11);
      run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 6'd12);
      run_op("div_by0", 2'b00, 32'd77, 32'd0, 6'd13);
      run_op("remu_by0", 2'b11, 32'h1234, 32'd0, 6'd14);
      run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 6'd15);
      run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 6'd16);
      run_op("rem_small", 2'b10, 32'd3, 32'hFFFF_FFF0, 6'd17);

      // Flush during BUSY iteration 10
      issue_valid = 1'b1; issue_op = 2'b00; issue_a = 32'd1000; issue_b = 32'd7; issue_tag = 6'd20;
      @(negedge clk);
      issue_valid = 1'b0;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy/ready", 64'(issue_ready), 64'd1);
      check("flush_busy/busy", 64'(busy), 64'd0);
      count_pulses(40, n);
      check("flush_busy/no_result", 64'(n), 64'd0);
      run_op("after_flush_divu_9_3", 2'b01, 32'd9, 32'd3, 6'd21);

      // Accept in the flush cycle is dropped
      issue_valid = 1'b1; issue_op = 2'b01; issue_a = 32'd50; issue_b = 32'd5; issue_tag = 6'd22;
      flush = 1'b1;
      @(negedge clk);
      issue_valid = 1'b0;
      flush = 1'b0;
      check("flush_accept/busy", 64'(busy), 64'd0);
      count_pulses(40, n);
      check("flush_accept/no_result", 64'(n), 64'd0);

      // Flush landing in FINISH discards the result
      issue_valid = 1'b1; issue_op = 2'b01; issue_a = 32'd1000; issue_b = 32'd7; issue_tag = 6'd23;
      @(negedge clk);
      issue_valid = 1'b0;
      repeat (32) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_finish/res_valid", 64'(res_valid), 64'd0);
      check("flush_finish/busy", 64'(busy), 64'd0);

      // Reset mid-op loses the op
      issue_valid = 1'b1; issue_op = 2'b01; issue_a = 32'd999; issue_b = 32'd4; issue_tag = 6'd24;
      @(negedge clk);
      issue_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid/busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      count_pulses(40, n);
      check("rst_mid/no_result", 64'(n), 64'd0);

      // Back-to-back: valid held, second op accepted in first's res_valid cycle
      issue_valid = 1'b1; issue_op = 2'b01; issue_a = 32'd1000; issue_b = 32'd3; issue_tag = 6'd1;
      @(negedge clk);
      issue_op = 2'b11; issue_a = 32'd1000; issue_b = 32'd7; issue_tag = 6'd2;
      lat = 1;
      while (!res_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check("b2b/lat1", 64'(lat), 64'd34);
      check("b2b/val1", 64'(res_value), 64'd333);
      check("b2b/tag1", 64'(res_tag), 64'd1);
      @(negedge clk);
      issue_valid = 1'b0;
      check("b2b/second_busy", 64'(busy), 64'd1);
      lat = 1;
      while (!res_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check("b2b/gap", 64'(lat), 64'd34);
      check("b2b/val2", 64'(res_value), 64'd6);
      check("b2b/tag2", 64'(res_tag), 64'd2);
      @(negedge clk);

      // Randomized ops
      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom);
         ra  = $urandom;
         rb  = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 1) == 1) rb = 32'(-rb);
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: begin ra = $urandom_range(0, 100); rb = $urandom_range(101, 100000); end
            3: ra = $urandom >> $urandom_range(0, 31);
            default: ;
         endcase
         run_op("rand", rop, ra, rb, 6'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
